// File: rtl/display_scan_mux.sv
// display_scan_mux: frame-coherent 7-segment digit scanner with dead time; DISPLAY_SCAN_LZB_EN enables leading-zero blanking
module display_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 12000,
  parameter int DEAD_CYCLES = 600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank,
  output logic [3:0]            number,
  output logic [DIGITS-1:0]     digits_n,
  output logic                  frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [4*DIGITS-1:0] pending_q, pending_d, shadow_q, shadow_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          number_q, number_d;
  logic [DIGITS-1:0]   digits_n_q, digits_n_d;
  logic                frame_start_q, frame_start_d;
  logic                last, wrap, gap, supp;
`ifdef DISPLAY_SCAN_LZB_EN
  assign supp = idx_q != '0 && (shadow_q >> {idx_q, 2'b00}) == '0;
`else
  assign supp = 1'b0;
`endif
  always_comb begin
    last          = cnt_q == CW'(REFRESH_DIV - 1);
    wrap          = last && idx_q == IW'(DIGITS - 1);
    gap           = int'(cnt_q) < DEAD_CYCLES;
    cnt_d         = last ? '0 : cnt_q + CW'(1);
    idx_d         = wrap ? '0 : last ? idx_q + IW'(1) : idx_q;
    pending_d     = load ? value : pending_q;
    shadow_d      = wrap ? pending_d : shadow_q;
    number_d      = shadow_q[{idx_q, 2'b00} +: 4];
    digits_n_d    = (gap || blank || supp) ? '1 : ~(DIGITS'(1) << idx_q);
    frame_start_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      shadow_q      <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      number_q      <= '0;
      digits_n_q    <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      number_q      <= number_d;
      digits_n_q    <= digits_n_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign number      = number_q;
  assign digits_n    = digits_n_q;
  assign frame_start = frame_start_q;
endmodule
